// File: rtl/axi_crossbar_addr_arb_if.sv
// Address-arbiter bundle: per-source requests, the granted master address channel
// and the W-burst ownership report. The arbiter takes the slave modport.
interface axi_crossbar_addr_arb_if #(
  parameter int S_COUNT = 4
);
  localparam int IDX_W = $clog2(S_COUNT);

  logic [S_COUNT-1:0]   s_req_valid;
  logic [S_COUNT*4-1:0] s_req_qos;
  logic [S_COUNT-1:0]   s_req_ready;
  logic [IDX_W-1:0]     m_grant_index;
  logic                 m_a_valid;
  logic                 m_a_ready;
  logic [IDX_W-1:0]     m_w_select;
  logic                 m_w_valid;
  logic                 m_w_last_hs;

  modport slave (
    input  s_req_valid, s_req_qos, m_a_ready, m_w_last_hs,
    output s_req_ready, m_grant_index, m_a_valid, m_w_select, m_w_valid
  );

  modport master (
    output s_req_valid, s_req_qos, m_a_ready, m_w_last_hs,
    input  s_req_ready, m_grant_index, m_a_valid, m_w_select, m_w_valid
  );
endinterface

// File: rtl/axi_crossbar_arb_prio.sv
// Combinational selector: among requesters holding the highest qos (or all of them
// when qos is disabled), picks the first index at or after rr_ptr, wrapping.
module axi_crossbar_arb_prio #(
  parameter int N          = 4,
  parameter int QOS_ENABLE = 1
) (
  input  logic [N-1:0]         req,
  input  logic [N*4-1:0]       qos,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic                 grant_vld,
  output logic [$clog2(N)-1:0] grant_idx
);
  localparam int IDX_W = $clog2(N);

  logic [3:0]   max_qos;
  logic [N-1:0] elig;

  always_comb begin
    max_qos = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (qos[4*i +: 4] > max_qos)) max_qos = qos[4*i +: 4];
    end
    for (int i = 0; i < N; i++) begin
      elig[i] = req[i] && ((QOS_ENABLE == 0) || (qos[4*i +: 4] == max_qos));
    end
  end

  // N need not be a power of two, so the rotated index wraps explicitly.
  always_comb begin
    int j;
    j         = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      if (!grant_vld && elig[j]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/axi_crossbar_addr_arb.sv
// Per-master address arbiter: registers one winner, holds it until the master accepts,
// and (for write masters) remembers grant order so W beats follow their addresses.
module axi_crossbar_addr_arb #(
  parameter int S_COUNT      = 4,
  parameter int QOS_ENABLE   = 1,
  parameter int WRITE        = 0,
  parameter int W_FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_crossbar_addr_arb_if.slave bus
);
  localparam int IDX_W = $clog2(S_COUNT);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             arb_vld;
  logic [IDX_W-1:0] arb_idx;
  logic             fifo_full;
  logic             a_hs;

  axi_crossbar_arb_prio #(
    .N          (S_COUNT),
    .QOS_ENABLE (QOS_ENABLE)
  ) u_prio (
    .req       (bus.s_req_valid),
    .qos       (bus.s_req_qos),
    .rr_ptr    (rr_ptr_q),
    .grant_vld (arb_vld),
    .grant_idx (arb_idx)
  );

  assign a_hs = (state_q == ST_GRANT) && bus.m_a_ready;

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_vld && !fifo_full) begin
          state_d     = ST_GRANT;
          grant_idx_d = arb_idx;
        end
      end
      default: begin
        // The grant is never withdrawn: only the master's accept ends it.
        if (a_hs) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (grant_idx_q == IDX_W'(S_COUNT - 1)) ? '0 : grant_idx_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.m_a_valid     = (state_q == ST_GRANT);
  assign bus.m_grant_index = grant_idx_q;

  always_comb begin
    bus.s_req_ready = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      bus.s_req_ready[i] = a_hs && (grant_idx_q == IDX_W'(i));
    end
  end

  generate
    if (WRITE != 0) begin : g_wfifo
      localparam int PTR_W = $clog2(W_FIFO_DEPTH);

      logic [IDX_W-1:0] mem_q [W_FIFO_DEPTH];
      logic [IDX_W-1:0] mem_d [W_FIFO_DEPTH];
      logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
      logic [PTR_W:0]   count_q, count_d;
      logic             pop;

      // A handshake can only start while not full, so its push always fits.
      assign pop = bus.m_w_last_hs && (count_q != '0);

      always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (a_hs) begin
          mem_d[wr_ptr_q] = grant_idx_q;
          wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (a_hs && !pop) count_d = count_q + 1'b1;
        else if (!a_hs && pop) count_d = count_q - 1'b1;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
        end
      end

      always_ff @(posedge clk) begin
        mem_q <= mem_d;
      end

      assign fifo_full      = (count_q == (PTR_W + 1)'(W_FIFO_DEPTH));
      assign bus.m_w_select = mem_q[rd_ptr_q];
      assign bus.m_w_valid  = (count_q != '0);
    end else begin : g_no_wfifo
      logic unused_w_last;
      assign unused_w_last  = bus.m_w_last_hs;
      assign fifo_full      = 1'b0;
      assign bus.m_w_select = '0;
      assign bus.m_w_valid  = 1'b0;
    end
  endgenerate
endmodule

// File: doc/axi_crossbar_addr_arb.md
AXI_CROSSBAR_ADDR_ARB -- requirements
Module: axi_crossbar_addr_arb

Interface
REQ-001 SHALL have parameter S_COUNT, default 4: number of requesting slave interfaces (2..16).
REQ-002 SHALL have parameter QOS_ENABLE, default 1: 1 = highest aqos wins; 0 = pure round-robin.
REQ-003 SHALL have parameter WRITE, default 0: 1 = track W-channel routing order in an internal FIFO.
REQ-004 SHALL have parameter W_FIFO_DEPTH, default 4: W routing FIFO entries, a power of two (2..32).
REQ-005 SHALL have port clk, input, 1 bit: clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port s_req_valid, input, S_COUNT bits: per-source address valid, already decoded to this master.
REQ-008 SHALL have port s_req_qos, input, S_COUNT*4 bits: per-source aqos; source i uses bits [4i+3:4i].
REQ-009 SHALL have port s_req_ready, output, S_COUNT bits: per-source address accept.
REQ-010 SHALL have port m_grant_index, output, clog2(S_COUNT) bits: selected source, drives the address mux.
REQ-011 SHALL have port m_a_valid, output, 1 bit: master address valid.
REQ-012 SHALL have port m_a_ready, input, 1 bit: master address ready.
REQ-013 SHALL have port m_w_select, output, clog2(S_COUNT) bits: source owning the current W burst.
REQ-014 SHALL have port m_w_valid, output, 1 bit: m_w_select is meaningful.
REQ-015 SHALL have port m_w_last_hs, input, 1 bit: master-side wvalid & wready & wlast.

Function
REQ-016 SHALL implement states IDLE and GRANT.
REQ-017 SHALL, in IDLE with any s_req_valid bit set and (WRITE=0 or FIFO count < W_FIFO_DEPTH), register a winner and enter GRANT on the next edge.
REQ-018 SHALL pick the winner, when QOS_ENABLE=1, only from valid sources with the maximum qos value.
REQ-019 SHALL break ties round-robin, scanning indices from the RR pointer upward with wrap-around (pointer reset value 0).
REQ-020 SHALL hold m_a_valid=1 and a constant m_grant_index throughout GRANT, even if the granted s_req_valid drops (no grant withdrawal).
REQ-021 SHALL drive s_req_ready[i] combinationally as m_a_ready & (state==GRANT) & (m_grant_index==i), with all other bits 0.
REQ-022 SHALL, on the handshake (GRANT & m_a_ready), set the RR pointer to winner+1 mod S_COUNT, clear m_a_valid, and return to IDLE.
REQ-023 SHALL give a throughput of at most one grant per 2 cycles, with request-to-m_a_valid latency of 1 cycle.
REQ-024 SHALL, when WRITE=1, push the winner index into the FIFO on each address handshake.
REQ-025 SHALL, when WRITE=1, pop the FIFO on m_w_last_hs while m_w_valid=1.
REQ-026 SHALL drive m_w_select as the FIFO head and m_w_valid as (count != 0).
REQ-027 SHALL, on a simultaneous push and pop, leave the count unchanged and advance both pointers.
REQ-028 SHALL ignore m_w_last_hs while the FIFO is empty.
REQ-029 SHALL block arbitration in IDLE while the FIFO is full; a handshake in progress completes and its push is always accepted.
REQ-030 SHALL, when WRITE=0, tie m_w_valid=0 and m_w_select=0 and infer no FIFO storage.

Reset
REQ-031 SHALL, on rst, set state=IDLE, m_a_valid=0, m_grant_index=0, RR pointer=0, FIFO count and pointers=0, m_w_valid=0, s_req_ready=0.
REQ-032 SHALL, on rst asserted mid-GRANT, drop m_a_valid on the next edge, issue no push, and discard FIFO contents.

Structure
REQ-033 SHALL place no shared package contents; no typedefs are needed, and the state encodings are local constants.
REQ-034 SHALL use one natural sub-module, axi_crossbar_arb_prio: combinational qos-max plus round-robin priority selector, reusable by the R/B arbiters.

Verification
REQ-035 SHALL verify: S_COUNT=4, QOS_ENABLE=0, all valid, m_a_ready=1 -> grants 0,1,2,3,0 every 2 cycles.
REQ-036 SHALL verify: QOS_ENABLE=1, qos={src0:2, src1:7, src2:7, src3:0}, all valid -> grants 1,2,1,2; sources 0 and 3 are never served while 1 and 2 stay valid.
REQ-037 SHALL verify: grant to src2 with m_a_ready=0 for 5 cycles and src2 valid dropped -> m_a_valid and index 2 held for 5 cycles; s_req_ready[2] pulses on the 6th.
REQ-038 SHALL verify: WRITE=1, W_FIFO_DEPTH=2, two grants (3 then 1) with no wlast -> m_w_select=3, arbitration stalls with a third source valid; one m_w_last_hs -> m_w_select=1 and arbitration resumes.
REQ-039 SHALL verify: push and pop in the same cycle at count=1 -> count stays 1 and the head advances to the new entry.
REQ-040 SHALL verify: rst asserted during GRANT -> next cycle m_a_valid=0, m_w_valid=0, and the first post-reset grant is the lowest valid index.
